// File: rtl/pdu_input_conditioner.sv
// Purpose: 2-FF synchroniser, debounce counter and edge pulses for the pdu's run/step/valid buttons and the in switch bank.
// Latency: a raw change stable before an edge appears on the level outputs and pulses CNT_MAX+2 edges later.
// Backpressure: none; each channel is free-running and has no handshake.
module pdu_input_conditioner #(
    parameter int CNT_MAX = 1000000,
    parameter int SW_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run_raw,
    input  logic            step_raw,
    input  logic            valid_raw,
    input  logic [SW_W-1:0] in_raw,
    output logic            run,
    output logic            step,
    output logic            step_p,
    output logic            valid,
    output logic            valid_p,
    output logic [SW_W-1:0] in,
    output logic [SW_W-1:0] in_chg,
    output logic            any_chg
);

    localparam int N  = 3 + SW_W;
    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    // Channel order: bit 0 run, bit 1 step, bit 2 valid, bits 3.. in switches.
    logic [N-1:0]  raw;
    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  db;
    logic [N-1:0]  acc;
    logic [CW-1:0] cnt [N];

    assign raw = {in_raw, valid_raw, step_raw, run_raw};

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc[i] = (s2[i] != db[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            db      <= '0;
            step_p  <= 1'b0;
            valid_p <= 1'b0;
            in_chg  <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            // An accepted channel always differs from db, so flipping loads s2.
            db      <= db ^ acc;
            step_p  <= acc[1] & s2[1];
            valid_p <= acc[2] & s2[2];
            in_chg  <= acc[N-1:3];
            for (int i = 0; i < N; i++) begin
                if (s2[i] == db[i] || acc[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign run     = db[0];
    assign step    = db[1];
    assign valid   = db[2];
    assign in      = db[N-1:3];
    assign any_chg = |in_chg;

endmodule

// File: tb/tb_pdu_input_conditioner.sv
// Bench for pdu_input_conditioner with CNT_MAX=4: directed scenarios plus random raw activity against a window-based model.
module tb_pdu_input_conditioner;

    localparam int CNT_MAX = 4;
    localparam int SW_W    = 5;
    localparam int N       = 3 + SW_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            run_raw, step_raw, valid_raw;
    logic [SW_W-1:0] in_raw;
    logic            run, step, step_p, valid, valid_p, any_chg;
    logic [SW_W-1:0] in, in_chg;

    pdu_input_conditioner #(.CNT_MAX(CNT_MAX), .SW_W(SW_W)) dut (
        .clk(clk), .rst(rst),
        .run_raw(run_raw), .step_raw(step_raw), .valid_raw(valid_raw), .in_raw(in_raw),
        .run(run), .step(step), .step_p(step_p), .valid(valid), .valid_p(valid_p),
        .in(in), .in_chg(in_chg), .any_chg(any_chg)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_stepp = 0;

    // Model: raw history per edge; a channel takes value v when the last CNT_MAX
    // synchronised samples (raw seen two edges earlier) all equal v and v != level.
    logic [N-1:0] hist [$];
    logic [N-1:0] m_db, m_rise, m_chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_db   = '0;
        m_rise = '0;
        m_chg  = '0;
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [N-1:0] nd;
        logic         v, stable;
        int           sz;
        nd = m_db;
        hist.push_back({in_raw, valid_raw, step_raw, run_raw});
        if (hist.size() > 16) void'(hist.pop_front());
        sz = hist.size();
        for (int ch = 0; ch < N; ch++) begin
            v = hist[sz-3][ch];
            stable = 1'b1;
            for (int j = 3; j < 3 + CNT_MAX; j++) begin
                if (hist[sz-j][ch] != v) stable = 1'b0;
            end
            if (stable && v != m_db[ch]) nd[ch] = v;
        end
        m_rise = nd & ~m_db;
        m_chg  = nd ^ m_db;
        m_db   = nd;
    endtask

    task automatic compare_all();
        check("levels", {24'd0, in, valid, step, run}, {24'd0, m_db});
        check("pulses", {30'd0, valid_p, step_p}, {30'd0, m_rise[2], m_rise[1]});
        check("in_chg", {27'd0, in_chg}, {27'd0, m_chg[N-1:3]});
        check("any_chg", {31'd0, any_chg}, {31'd0, |m_chg[N-1:3]});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_reset();
            else model_edge();
            #1;
            compare_all();
            if (step_p) n_stepp++;
        end
    endtask

    task automatic assert_rst(input int n);
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        cycles(n);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {run_raw, step_raw, valid_raw} = 3'b111;
        in_raw = '1;
        model_reset();

        // Reset with all raw high, then release.
        cycles(3);
        rst = 1'b0;
        n_stepp = 0;
        cycles(5);
        check("rst_rel_pre", {29'd0, run, step, valid}, 32'd0);
        cycles(1);
        check("rst_rel_lvl", {27'd0, in}, 32'h1f);
        check("rst_rel_chg", {26'd0, any_chg, in_chg}, 32'h3f);
        check("rst_rel_p", {30'd0, step_p, valid_p}, 32'h3);
        cycles(4);
        check("rst_rel_once", n_stepp, 1);

        {run_raw, step_raw, valid_raw} = 3'b000;
        in_raw = '0;
        cycles(10);

        // Clean press and release.
        n_stepp = 0;
        step_raw = 1'b1;
        cycles(5);
        check("press_pre", {31'd0, step}, 32'd0);
        cycles(1);
        check("press_edge", {30'd0, step, step_p}, 32'h3);
        cycles(14);
        check("press_once", n_stepp, 1);
        step_raw = 1'b0;
        cycles(5);
        check("rel_pre", {31'd0, step}, 32'd1);
        cycles(1);
        check("rel_edge", {30'd0, step, step_p}, 32'h0);
        cycles(4);
        check("rel_no_p", n_stepp, 1);

        // Bounce: toggle every 2 cycles, then hold high.
        n_stepp = 0;
        for (int i = 0; i < 6; i++) begin
            step_raw = ~step_raw;
            cycles(2);
        end
        check("bounce_none", n_stepp, 0);
        step_raw = 1'b1;
        cycles(5);
        check("bounce_pre", n_stepp, 0);
        cycles(1);
        check("bounce_edge", {31'd0, step_p}, 32'd1);
        cycles(6);
        check("bounce_once", n_stepp, 1);

        // Switch entry.
        in_raw = 5'b00101;
        cycles(6);
        check("sw1_lvl", {27'd0, in}, 32'h05);
        check("sw1_chg", {27'd0, in_chg}, 32'h05);
        in_raw = 5'b00100;
        cycles(6);
        check("sw2_chg", {26'd0, any_chg, in_chg}, 32'h21);
        cycles(1);
        check("sw2_done", {31'd0, any_chg}, 32'd0);

        // Simultaneous run/valid rise.
        {run_raw, valid_raw} = 2'b11;
        cycles(6);
        check("simul", {30'd0, run, valid_p}, 32'h3);

        // Reset mid-count restarts the debounce.
        step_raw = 1'b0;
        cycles(10);
        step_raw = 1'b1;
        n_stepp = 0;
        cycles(3);
        assert_rst(2);
        cycles(5);
        check("rstmid_pre", n_stepp, 0);
        cycles(1);
        check("rstmid_edge", {31'd0, step_p}, 32'd1);

        // Random raw activity with occasional resets.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) != 0) step_raw  = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) run_raw   = ~run_raw;
            if ($urandom_range(0, 3) == 0) valid_raw = ~valid_raw;
            if ($urandom_range(0, 2) == 0) in_raw    = SW_W'($urandom);
            if ($urandom_range(0, 19) == 0) assert_rst($urandom_range(1, 3));
            cycles($urandom_range(1, 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
